imem_loader: RTL and testbench

- Write-side companion to the instruction memory. Receives a length-prefixed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into the instruction array.
- Word addresses advance by 4, matching the fetch side's byte-address indexing.
- Holds the core stalled while loading. Runs before the pipeline is released.

---
 rtl/imem_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed byte image into the instruction array.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned DEPTH     = 100,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_stall,
  output logic        done,
  output logic        err,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  state_t      state;
  logic [7:0]  n_lo;
  logic [15:0] n;
  logic [1:0]  cnt;
  logic [23:0] shreg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic        accept;
  logic [15:0] n_rx;
  logic [31:0] last_addr;
  logic [31:0] limit;
  logic        ovf;
  logic [15:0] ww_next;

  assign accept    = byte_valid && byte_ready;
  assign n_rx      = {byte_data, n_lo};
  assign last_addr = BASE_ADDR + ({16'h0, n_rx} - 32'd1) * ADDR_STEP;
  assign limit     = DEPTH - 32'd4;
  assign ovf       = last_addr > limit;
  assign ww_next   = words_written + 16'd1;

  // Load sequencer: header, byte assembly, write strobe, completion flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      byte_ready    <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= BASE_ADDR;
      mem_wdata     <= 32'h0;
      cpu_stall     <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= 16'h0;
      n_lo          <= 8'h0;
      n             <= 16'h0;
      cnt           <= 2'd0;
      shreg         <= 24'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum          <= 8'h0;
`endif
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state         <= LEN0;
            byte_ready    <= 1'b1;
            cpu_stall     <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            words_written <= 16'h0;
            mem_addr      <= BASE_ADDR;
            cnt           <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= 8'h0;
`endif
          end
        end
        LEN0: begin
          if (accept) begin
            n_lo  <= byte_data;
            state <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            n <= n_rx;
            if (n_rx == 16'h0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state      <= CSUM;
`else
              state      <= DONE;
              byte_ready <= 1'b0;
              cpu_stall  <= 1'b0;
              done       <= 1'b1;
`endif
            end else if (ovf) begin
              state      <= ERR;
              byte_ready <= 1'b0;
              cpu_stall  <= 1'b0;
              err        <= 1'b1;
            end else begin
              state <= DATA;
              cnt   <= 2'd0;
            end
          end
        end
        DATA: begin
          if (accept) begin
            cnt   <= cnt + 2'd1;
            shreg <= {byte_data, shreg[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum  <= csum ^ byte_data;
`endif
            if (cnt == 2'd3) begin
              state      <= WRITE;
              mem_we     <= 1'b1;
              mem_wdata  <= {byte_data, shreg};
              byte_ready <= 1'b0;
            end
          end
        end
        WRITE: begin
          words_written <= ww_next;
          mem_addr      <= mem_addr + ADDR_STEP;
          if (ww_next == n) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= CSUM;
            byte_ready <= 1'b1;
`else
            state     <= DONE;
            cpu_stall <= 1'b0;
            done      <= 1'b1;
`endif
          end else begin
            state      <= DATA;
            byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            byte_ready <= 1'b0;
            cpu_stall  <= 1'b0;
            if (byte_data == csum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random and directed image loads checked
// against a transaction-level model of the expected writes.
module tb_imem_loader;

  localparam int unsigned DEPTH = 100;
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [31:0] STEP  = 32'd4;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_stall;
  logic        done;
  logic        err;
  logic [15:0] words_written;

  imem_loader #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .ADDR_STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_stall(cpu_stall), .done(done), .err(err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  wr_t expq[$];
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  int log_c[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // every write strobe must match the next modelled write
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      wr_t e;
      check("we_ready_low", {31'h0, byte_ready}, 32'h0);
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we: got addr %h data %h want none",
                 mem_addr, mem_wdata);
      end else begin
        e = expq.pop_front();
        check("we_addr", mem_addr, e.addr);
        check("we_data", mem_wdata, e.data);
      end
      log_a.push_back(mem_addr);
      log_d.push_back(mem_wdata);
      log_c.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: valid held, 1: one idle cycle per byte, 2: random gaps
  task automatic send(input logic [7:0] b, input int mode,
                      input bit rnd_start);
    int t;
    bit acc;
    if (mode == 1) begin
      byte_valid = 1'b0;
      tick();
    end else if (mode == 2) begin
      for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
        byte_valid = 1'b0;
        tick();
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    forever begin
      acc   = byte_ready;
      start = rnd_start && ($urandom_range(0, 7) == 0);
      tick();
      start = 1'b0;
      if (acc) break;
      t++;
      if (t > 40) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: byte %h not accepted in 40 cycles", b);
        break;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    for (int t = 0; t < 30 && !(done || err); t++) tick();
  endtask

  task automatic do_load(input logic [15:0] n, input bq_t d,
                         input int mode, input bit bad,
                         input bit rnd_start);
    logic [7:0] cs;
    bit ovf;
    bit csbad;
    int ni;
    cs = 8'h0;
    csbad = 1'b0;
    ni = int'(n);
    ovf = (ni != 0) &&
          (longint'(BASE) + longint'(ni - 1) * longint'(STEP)
           > longint'(DEPTH) - 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_stall", {31'h0, cpu_stall}, 32'h1);
    check("start_done", {31'h0, done}, 32'h0);
    check("start_err", {31'h0, err}, 32'h0);
    check("start_ww", {16'h0, words_written}, 32'h0);
    if (!ovf)
      for (int i = 0; i < ni; i++)
        expq.push_back('{BASE + 32'(i) * STEP,
                         {d[4*i+3], d[4*i+2], d[4*i+1], d[4*i]}});
    send(n[7:0], mode, rnd_start);
    send(n[15:8], mode, rnd_start);
    if (ovf) begin
      check("ovf_err_now", {31'h0, err}, 32'h1);
      check("ovf_stall", {31'h0, cpu_stall}, 32'h0);
    end else begin
      for (int i = 0; i < 4 * ni; i++) begin
        send(d[i], mode, rnd_start);
        cs ^= d[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      csbad = bad;
      send(bad ? ~cs : cs, mode, rnd_start);
`endif
    end
    wait_end();
    check("end_done", {31'h0, done}, {31'h0, !ovf && !csbad});
    check("end_err", {31'h0, err}, {31'h0, ovf || csbad});
    check("end_ww", {16'h0, words_written}, ovf ? 32'h0 : 32'(ni));
    check("end_stall", {31'h0, cpu_stall}, 32'h0);
    check("end_pending", 32'(expq.size()), 32'h0);
  endtask

  function automatic bq_t rnd_bytes(input int cnt);
    bq_t q;
    for (int i = 0; i < cnt; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bq_t v;
    int l0;
    logic [15:0] n;

    tick();
    tick();
    check("rst_ready", {31'h0, byte_ready}, 32'h0);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    check("rst_addr", mem_addr, BASE);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_stall", {31'h0, cpu_stall}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_ww", {16'h0, words_written}, 32'h0);
    rst = 1'b0;
    tick();

    v = '{8'h93, 8'h00, 8'hE0, 8'h01, 8'h03, 8'h81, 8'h00, 8'h00};
    l0 = log_a.size();
    do_load(16'd2, v, 0, 1'b0, 1'b0);
    check("t1_nwr", 32'(log_a.size() - l0), 32'd2);
    if (log_a.size() - l0 == 2) begin
      check("t1_a0", log_a[l0], 32'h0);
      check("t1_d0", log_d[l0], 32'h01E00093);
      check("t1_a1", log_a[l0+1], 32'h4);
      check("t1_d1", log_d[l0+1], 32'h00008103);
      check("t1_gap", 32'(log_c[l0+1] - log_c[l0]), 32'd5);
    end

    l0 = log_a.size();
    do_load(16'd2, v, 1, 1'b0, 1'b0);
    check("t2_nwr", 32'(log_a.size() - l0), 32'd2);

    byte_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_ready", {31'h0, byte_ready}, 32'h0);
    end
    byte_valid = 1'b0;

    l0 = log_a.size();
    v = {};
    do_load(16'd26, v, 0, 1'b0, 1'b0);
    check("ovf_nwr", 32'(log_a.size() - l0), 32'd0);

    do_load(16'd0, v, 0, 1'b0, 1'b0);

    l0 = log_a.size();
    v = rnd_bytes(12);
    for (int i = 0; i < 3; i++)
      expq.push_back('{BASE + 32'(i) * STEP,
                       {v[4*i+3], v[4*i+2], v[4*i+1], v[4*i]}});
    start = 1'b1;
    tick();
    start = 1'b0;
    send(8'd3, 0, 1'b0);
    send(8'd0, 0, 1'b0);
    for (int i = 0; i < 6; i++) send(v[i], 0, 1'b0);
    rst = 1'b1;
    #1;
    check("mr_nwr", 32'(log_a.size() - l0), 32'd1);
    check("mr_ready", {31'h0, byte_ready}, 32'h0);
    check("mr_we", {31'h0, mem_we}, 32'h0);
    check("mr_addr", mem_addr, BASE);
    check("mr_wdata", mem_wdata, 32'h0);
    check("mr_stall", {31'h0, cpu_stall}, 32'h0);
    check("mr_done", {31'h0, done}, 32'h0);
    check("mr_err", {31'h0, err}, 32'h0);
    check("mr_ww", {16'h0, words_written}, 32'h0);
    expq.delete();
    tick();
    tick();
    check("mr_nwr_after", 32'(log_a.size() - l0), 32'd1);
    rst = 1'b0;
    tick();
    do_load(16'd3, rnd_bytes(12), 0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    v = '{8'h93, 8'h00, 8'hE0, 8'h01};
    do_load(16'd1, v, 0, 1'b0, 1'b0);
    l0 = log_a.size();
    do_load(16'd1, v, 0, 1'b1, 1'b0);
    check("cs_nwr", 32'(log_a.size() - l0), 32'd1);
    if (log_a.size() - l0 == 1) begin
      check("cs_a0", log_a[l0], 32'h0);
      check("cs_d0", log_d[l0], 32'h01E00093);
    end
`endif

    for (int it = 0; it < 15; it++) begin
      n = 16'($urandom_range(0, 27));
      do_load(n, rnd_bytes(4 * int'(n)), 2,
              $urandom_range(0, 3) == 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
